// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS-subset controller:
// state encodings, opcode/funct fields, ALUOp and ALUControl codes.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } statetype_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOP = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps ALUOp (and Funct for R-type) to the 3-bit ALUControl.
// Unknown R-type functs select ALU_NOP so the ALU drives zero.
module aludec
  import mc_pkg::*;
#(
  parameter int FUNCT_W = 6
) (
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [2:0]         alu_control
);

  // Pure combinational decode of the ALU operation.
  always_comb begin
    alu_control = ALU_NOP;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alu_control = ALU_ADD;
          F_SUB:   alu_control = ALU_SUB;
          F_AND:   alu_control = ALU_AND;
          F_OR:    alu_control = ALU_OR;
          F_SLT:   alu_control = ALU_SLT;
          default: alu_control = ALU_NOP;
        endcase
      end
      default: alu_control = ALU_NOP;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Main Moore control FSM for the multicycle MIPS-subset CPU.
// Optional macro MC_CTRL_BNE_EN adds bne support via an IsBne flag.
//
// state   | meaning
// FETCH   | read instruction at PC into IR, PC <= PC+4
// DECODE  | read registers, precompute branch target
// MEMADR  | compute lw/sw address A + SignImm
// MEMRD   | read data memory at ALUOut
// MEMWB   | write loaded data to rt
// MEMWR   | write B to data memory at ALUOut
// EXECUTE | R-type ALU operation A op B
// ALUWB   | write ALUOut to rd
// BRANCH  | compare A-B, PC <= ALUOut if taken
// ADDIEX  | A + SignImm
// ADDIWB  | write ALUOut to rt
// JUMP    | PC <= jump target
module mc_controller
  import mc_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    Op,
  input  logic [FUNCT_W-1:0] Funct,
  input  logic               Zero,
  output logic               PCEn,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic [2:0]         ALUControl,
  output logic [3:0]         State
);

  statetype_t state_q, state_d, cur_state;
  logic [1:0] alu_op;
  logic       pc_write, branch, ir_write, mem_write, reg_write;
  logic       branch_taken;

`ifdef MC_CTRL_BNE_EN
  logic is_bne_q, is_bne_d;
`endif

  // Next-state selection; Op is only looked at in DECODE and MEMADR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       state_d = BRANCH;
`endif
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (Op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // State register with synchronous reset back to FETCH.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

`ifdef MC_CTRL_BNE_EN
  // Remember whether the branch being decoded is bne; cleared every FETCH.
  always_comb begin
    is_bne_d = is_bne_q;
    if (state_q == DECODE)     is_bne_d = (Op == OP_BNE);
    else if (state_q == FETCH) is_bne_d = 1'b0;
  end

  // IsBne flag register.
  always_ff @(posedge clk) begin
    if (reset) is_bne_q <= 1'b0;
    else       is_bne_q <= is_bne_d;
  end

  assign branch_taken = Zero ^ is_bne_q;
`else
  assign branch_taken = Zero;
`endif

  // While reset is high the outputs show FETCH, whatever the register holds.
  assign cur_state = reset ? FETCH : state_q;

  // Per-state Moore outputs; unlisted enables and selects stay 0.
  always_comb begin
    IorD      = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    PCSrc     = 2'b00;
    alu_op    = ALUOP_ADD;
    pc_write  = 1'b0;
    branch    = 1'b0;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    case (cur_state)
      FETCH: begin
        ALUSrcB  = 2'b01;
        ir_write = 1'b1;
        pc_write = 1'b1;
      end
      DECODE:  ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD:   IorD = 1'b1;
      MEMWB: begin
        MemtoReg  = 1'b1;
        reg_write = 1'b1;
      end
      MEMWR: begin
        IorD      = 1'b1;
        mem_write = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_FUNCT;
      end
      ALUWB: begin
        RegDst    = 1'b1;
        reg_write = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_SUB;
        PCSrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB:  reg_write = 1'b1;
      JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign IRWrite  = ir_write & ~reset;
  assign MemWrite = mem_write & ~reset;
  assign RegWrite = reg_write & ~reset;
  assign PCEn     = (pc_write | (branch & branch_taken)) & ~reset;
  assign State    = state_q;

  aludec #(
    .FUNCT_W(FUNCT_W)
  ) u_aludec (
    .alu_op      (alu_op),
    .funct       (Funct),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: a per-cycle vector table plus
// instruction-latency and bne sequences.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset, Zero;
  logic [5:0] Op, Funct;
  logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  int checks = 0;
  int failures = 0;

  mc_controller #(.OP_W(6), .FUNCT_W(6)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .ALUControl(ALUControl), .State(State)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
  localparam logic [5:0] J = 6'b000010, ILL = 6'b111111;

  // {PCEn,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA, ALUSrcB, PCSrc}
  localparam logic [11:0] X_FETCH = {8'b1001_0000, 2'b01, 2'b00};
  localparam logic [11:0] X_RST   = {8'b0000_0000, 2'b01, 2'b00};
  localparam logic [11:0] X_DEC   = {8'b0000_0000, 2'b11, 2'b00};
  localparam logic [11:0] X_MADR  = {8'b0000_0001, 2'b10, 2'b00};
  localparam logic [11:0] X_MRD   = {8'b0100_0000, 2'b00, 2'b00};
  localparam logic [11:0] X_MWB   = {8'b0000_0110, 2'b00, 2'b00};
  localparam logic [11:0] X_MWR   = {8'b0110_0000, 2'b00, 2'b00};
  localparam logic [11:0] X_EXE   = {8'b0000_0001, 2'b00, 2'b00};
  localparam logic [11:0] X_AWB   = {8'b0000_1010, 2'b00, 2'b00};
  localparam logic [11:0] X_BRT   = {8'b1000_0001, 2'b00, 2'b01};
  localparam logic [11:0] X_BRN   = {8'b0000_0001, 2'b00, 2'b01};
  localparam logic [11:0] X_AEX   = {8'b0000_0001, 2'b10, 2'b00};
  localparam logic [11:0] X_IWB   = {8'b0000_0010, 2'b00, 2'b00};
  localparam logic [11:0] X_JMP   = {8'b1000_0000, 2'b00, 2'b10};

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic [3:0]  st;
    logic [11:0] ctl;
    logic [2:0]  alu;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                              input logic z, input logic [3:0] st, input logic [11:0] ctl,
                              input logic [2:0] alu);
    vec_t v;
    v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.st = st; v.ctl = ctl; v.alu = alu;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Run one instruction from FETCH back to FETCH, counting cycles and watching writes.
  task automatic lat(input string name, input logic [5:0] op, input logic [5:0] fn,
                     input int exp_cycles, input logic exp_write);
    int n;
    logic saw;
    n = 0;
    saw = 1'b0;
    reset = 1'b0; Op = op; Funct = fn; Zero = 1'b0;
    #1;
    check({name, "_start"}, {28'd0, State}, 32'd0);
    do begin
      if (RegWrite || MemWrite) saw = 1'b1;
      @(posedge clk); #1;
      n++;
    end while (State != 4'd0 && n < 20);
    check({name, "_cycles"}, n, exp_cycles);
    check({name, "_write"}, {31'd0, saw}, {31'd0, exp_write});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // lw with reset held for two cycles, then R-type variants
    vecs.push_back(mk(1, LW, 0, 0, 0, X_RST, 3'b010));
    vecs.push_back(mk(0, LW, 0, 0, 0, X_FETCH, 3'b010));
    vecs.push_back(mk(0, LW, 0, 0, 1, X_DEC, 3'b010));
    vecs.push_back(mk(0, LW, 0, 0, 2, X_MADR, 3'b010));
    vecs.push_back(mk(0, LW, 0, 0, 3, X_MRD, 3'b010));
    vecs.push_back(mk(0, LW, 0, 0, 4, X_MWB, 3'b010));
    vecs.push_back(mk(0, RT, 6'b100010, 0, 0, X_FETCH, 3'b010));
    vecs.push_back(mk(0, RT, 6'b100010, 0, 1, X_DEC, 3'b010));
    vecs.push_back(mk(0, RT, 6'b100010, 0, 6, X_EXE, 3'b110));
    vecs.push_back(mk(0, RT, 6'b100010, 1, 7, X_AWB, 3'b010));
    vecs.push_back(mk(0, RT, 6'b101010, 0, 0, X_FETCH, 3'b010));
    vecs.push_back(mk(0, RT, 6'b101010, 0, 1, X_DEC, 3'b010));
    vecs.push_back(mk(0, RT, 6'b101010, 0, 6, X_EXE, 3'b111));
    vecs.push_back(mk(0, RT, 6'b101010, 0, 7, X_AWB, 3'b010));
    vecs.push_back(mk(0, RT, 6'b111111, 0, 0, X_FETCH, 3'b010));
    vecs.push_back(mk(0, RT, 6'b111111, 0, 1, X_DEC, 3'b010));
    vecs.push_back(mk(0, RT, 6'b111111, 1, 6, X_EXE, 3'b011));
    vecs.push_back(mk(0, RT, 6'b111111, 0, 7, X_AWB, 3'b010));
    // beq taken then not taken
    vecs.push_back(mk(0, BEQ, 0, 1, 0, X_FETCH, 3'b010));
    vecs.push_back(mk(0, BEQ, 0, 1, 1, X_DEC, 3'b010));
    vecs.push_back(mk(0, BEQ, 0, 1, 8, X_BRT, 3'b110));
    vecs.push_back(mk(0, BEQ, 0, 0, 0, X_FETCH, 3'b010));
    vecs.push_back(mk(0, BEQ, 0, 0, 1, X_DEC, 3'b010));
    vecs.push_back(mk(0, BEQ, 0, 0, 8, X_BRN, 3'b110));
    // sw, illegal, j, addi
    vecs.push_back(mk(0, SW, 0, 0, 0, X_FETCH, 3'b010));
    vecs.push_back(mk(0, SW, 0, 0, 1, X_DEC, 3'b010));
    vecs.push_back(mk(0, SW, 0, 0, 2, X_MADR, 3'b010));
    vecs.push_back(mk(0, SW, 0, 0, 5, X_MWR, 3'b010));
    vecs.push_back(mk(0, ILL, 0, 0, 0, X_FETCH, 3'b010));
    vecs.push_back(mk(0, ILL, 0, 0, 1, X_DEC, 3'b010));
    vecs.push_back(mk(0, J, 0, 0, 0, X_FETCH, 3'b010));
    vecs.push_back(mk(0, J, 0, 0, 1, X_DEC, 3'b010));
    vecs.push_back(mk(0, J, 0, 0, 11, X_JMP, 3'b010));
    vecs.push_back(mk(0, ADDI, 0, 0, 0, X_FETCH, 3'b010));
    vecs.push_back(mk(0, ADDI, 0, 0, 1, X_DEC, 3'b010));
    vecs.push_back(mk(0, ADDI, 0, 0, 9, X_AEX, 3'b010));
    vecs.push_back(mk(0, ADDI, 0, 0, 10, X_IWB, 3'b010));
    // reset in MEMRD abandons the lw, then a full lw follows
    vecs.push_back(mk(0, LW, 0, 0, 0, X_FETCH, 3'b010));
    vecs.push_back(mk(0, LW, 0, 0, 1, X_DEC, 3'b010));
    vecs.push_back(mk(0, LW, 0, 0, 2, X_MADR, 3'b010));
    vecs.push_back(mk(1, LW, 0, 0, 3, X_RST, 3'b010));
    vecs.push_back(mk(0, LW, 0, 0, 0, X_FETCH, 3'b010));
    vecs.push_back(mk(0, LW, 0, 0, 1, X_DEC, 3'b010));
    vecs.push_back(mk(0, LW, 0, 0, 2, X_MADR, 3'b010));
    vecs.push_back(mk(0, LW, 0, 0, 3, X_MRD, 3'b010));
    vecs.push_back(mk(0, LW, 0, 0, 4, X_MWB, 3'b010));

    reset = 1'b1; Op = LW; Funct = 6'd0; Zero = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; Op = vecs[i].op; Funct = vecs[i].fn; Zero = vecs[i].z;
      #2;
      check($sformatf("row%0d", i),
            {13'd0, State, PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
             ALUSrcA, ALUSrcB, PCSrc, ALUControl},
            {13'd0, vecs[i].st, vecs[i].ctl, vecs[i].alu});
      @(posedge clk); #1;
    end

    lat("lat_lw", LW, 6'd0, 5, 1'b1);
    lat("lat_sw", SW, 6'd0, 4, 1'b1);
    lat("lat_rtype", RT, 6'b100000, 4, 1'b1);
    lat("lat_addi", ADDI, 6'd0, 4, 1'b1);
    lat("lat_beq", BEQ, 6'd0, 3, 1'b0);
    lat("lat_j", J, 6'd0, 3, 1'b0);
    lat("lat_ill", ILL, 6'd0, 2, 1'b0);
`ifdef MC_CTRL_BNE_EN
    lat("lat_bne", BNE, 6'd0, 3, 1'b0);
    // bne: taken when Zero=0, not taken when Zero=1
    Op = BNE; Zero = 1'b0; #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("bne_state", {28'd0, State}, 32'd8);
    check("bne_taken", {31'd0, PCEn}, 32'd1);
    Zero = 1'b1; #1;
    check("bne_not_taken", {31'd0, PCEn}, 32'd0);
    @(posedge clk); #1;
    // a following beq must not inherit the bne polarity
    Op = BEQ; Zero = 1'b0; #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("beq_after_bne", {31'd0, PCEn}, 32'd0);
    @(posedge clk); #1;
`else
    lat("lat_bne_illegal", BNE, 6'd0, 2, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Moore-style main control FSM plus ALU decoder for the multicycle 32-bit MIPS-subset CPU.
- Sits directly upstream of the alu: produces ALUControl[2:0] and the SrcA/SrcB mux selects every cycle.
- Also produces the datapath enables for PC, instruction register, memory and register file.
- Inputs are the opcode and funct fields from the instruction register, and the ALU Zero flag.

Parameters:
- OP_W, 6, opcode field width
- FUNCT_W, 6, funct field width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- Op  in  OP_W  instruction[31:26]
- Funct  in  FUNCT_W  instruction[5:0]
- Zero  in  1  alu result == 0
- PCEn  out  1  PC register enable = PCWrite | (Branch & branch condition)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register enable
- RegDst  out  1  write register select: 0 = rt, 1 = rd
- MemtoReg  out  1  writeback select: 0 = ALUOut, 1 = Data
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  SrcA select: 0 = PC, 1 = register A
- ALUSrcB  out  2  SrcB select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- PCSrc  out  2  next PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- ALUControl  out  3  alu operation code
- State  out  4  current state encoding (debug)

Behaviour:
- Single clock domain; reset synchronous, active-high; all state updates on posedge clk.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- Reset: while reset=1, State:=FETCH at the edge. MemWrite, IRWrite, PCEn and RegWrite are forced 0 combinationally. Other outputs take their FETCH values.
- Reset mid-instruction: the instruction is abandoned and no further enables are issued for it.
- Outputs are pure functions of State (plus Funct/Zero where noted); no output registers.
- Transitions:
  - FETCH -> DECODE.
  - DECODE, by Op: 100011 or 101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; any other Op -> FETCH (treated as NOP, no writes).
  - MEMADR -> MEMRD if Op=100011, else MEMWR.
  - MEMRD -> MEMWB. EXECUTE -> ALUWB. ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
- Op is sampled in DECODE and MEMADR only; IR is stable then.
- Per-state outputs (unlisted enables = 0, unlisted selects = 0):
  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=1, PCWrite=1.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD: IorD=1.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
  - MEMWR: IorD=1, MemWrite=1.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
  - JUMP: PCSrc=10, PCWrite=1.
- ALU decoder (combinational):
  - ALUOp 00 -> 010 (add); 01 -> 110 (sub).
  - ALUOp 10, by Funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111 (slt); any other Funct -> 011 (alu outputs 0).
  - ALUOp 11 -> 011.
- PCEn = PCWrite | (Branch & Zero).
- Instruction latency in cycles, FETCH inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.

Optional Feature:
- MC_CTRL_BNE_EN defined: DECODE with Op=000101 -> BRANCH, and PCEn uses (Branch & (Zero ^ IsBne)). IsBne is a register set in DECODE from Op=000101 and cleared on reset and in FETCH.
- Not defined: Op=000101 is an illegal opcode (-> FETCH, no writes) and no IsBne register exists.

Decomposition:
- Package mc_pkg holds:
  - state enum type statetype_t (4-bit, encodings above);
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J;
  - funct constants F_ADD, F_SUB, F_AND, F_OR, F_SLT;
  - ALUControl constants ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_NOP=011, ALU_SUB=110, ALU_SLT=111.
- One sub-module, aludec (ALUOp, Funct -> ALUControl), instantiated inside mc_controller.

Test Plan:
- Reset held 2 cycles, then released with Op=100011 -> State sequence 0,1,2,3,4,0. Enables are 0 during reset. RegWrite=1 and MemtoReg=1 only in MEMWB.
- Op=000000 with Funct=100010, then 101010, then 111111 -> ALUControl in EXECUTE = 110, then 111, then 011. RegWrite=1 and RegDst=1 in ALUWB.
- Op=000100 in BRANCH state -> PCEn=1 when Zero=1 and PCEn=0 when Zero=0. PCSrc=01, ALUControl=110.
- Op=101011 -> States 0,1,2,5,0. MemWrite=1 and IorD=1 only in MEMWR. RegWrite is never 1.
- Op=111111 -> States 0,1,0 with no MemWrite or RegWrite. Then Op=000010 -> States 0,1,11,0 with PCEn=1 and PCSrc=10 in JUMP.
- Reset asserted while in MEMRD -> State=0 on the next edge. MemWrite and RegWrite stay 0 throughout. With MC_CTRL_BNE_EN, Op=000101 and Zero=0 in BRANCH -> PCEn=1.
